// File: rtl/cpu_reg_bank_pkg.sv
// Shared definitions for the CPU control/status register bank.
// Register offsets, IND_CMD bit positions and reset values.
package cpu_reg_bank_pkg;

    localparam logic [7:0] OFF_VERSION   = 8'h00;
    localparam logic [7:0] OFF_SCRATCH   = 8'h01;
    localparam logic [7:0] OFF_CTRL      = 8'h02;
    localparam logic [7:0] OFF_STATUS    = 8'h03;
    localparam logic [7:0] OFF_IRQ_MASK  = 8'h04;
    localparam logic [7:0] OFF_EVT0_CNT  = 8'h05;
    localparam logic [7:0] OFF_IND_ADDR  = 8'h08;
    localparam logic [7:0] OFF_IND_WDATA = 8'h09;
    localparam logic [7:0] OFF_IND_CMD   = 8'h0A;
    localparam logic [7:0] OFF_IND_RDATA = 8'h0B;

    localparam int CMD_WR_BIT = 0;
    localparam int CMD_RD_BIT = 1;

    localparam int ST_BUSY = 0;
    localparam int ST_DONE = 1;
    localparam int ST_ERR  = 2;

    localparam logic [15:0] RST_DATA = 16'h0000;

    typedef enum logic {
        IND_IDLE,
        IND_REQ
    } ind_state_t;

endpackage

// File: rtl/cpu_ind_access.sv
// Indirect table access engine: one outstanding request,
// completed by tbl_ack or abandoned after a timeout.
module cpu_ind_access
    import cpu_reg_bank_pkg::*;
#(
    parameter int DW          = 16,
    parameter int TAW         = 16,
    parameter int TBL_TIMEOUT = 255
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           cmd_wr,
    input  logic [1:0]     cmd_bits,
    input  logic [TAW-1:0] ind_addr,
    input  logic [DW-1:0]  ind_wdata,
    output logic           busy,
    output logic           done,
    output logic           err,
    output logic [DW-1:0]  ind_rdata,
    output logic           tbl_req,
    output logic           tbl_we,
    output logic [TAW-1:0] tbl_addr,
    output logic [DW-1:0]  tbl_wdata,
    input  logic           tbl_ack,
    input  logic [DW-1:0]  tbl_rdata
);

    localparam logic [7:0] TO_LAST = 8'(TBL_TIMEOUT - 1);

    ind_state_t state;
    logic [7:0] cnt;
    logic       start;

    assign start = cmd_wr & (cmd_bits[CMD_WR_BIT] | cmd_bits[CMD_RD_BIT]);
    assign busy  = (state == IND_REQ);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IND_IDLE;
            cnt       <= '0;
            done      <= 1'b0;
            err       <= 1'b0;
            ind_rdata <= '0;
            tbl_req   <= 1'b0;
            tbl_we    <= 1'b0;
            tbl_addr  <= '0;
            tbl_wdata <= '0;
        end else begin
            unique case (state)
                IND_IDLE: begin
                    if (start) begin
                        state     <= IND_REQ;
                        cnt       <= '0;
                        done      <= 1'b0;
                        err       <= 1'b0;
                        tbl_req   <= 1'b1;
                        // a write request wins when both start bits are set
                        tbl_we    <= cmd_bits[CMD_WR_BIT];
                        tbl_addr  <= ind_addr;
                        tbl_wdata <= ind_wdata;
                    end
                end
                IND_REQ: begin
                    if (tbl_ack) begin
                        state   <= IND_IDLE;
                        done    <= 1'b1;
                        tbl_req <= 1'b0;
                        tbl_we  <= 1'b0;
                        if (!tbl_we) begin
                            ind_rdata <= tbl_rdata;
                        end
                    end else if (cnt == TO_LAST) begin
                        state   <= IND_IDLE;
                        err     <= 1'b1;
                        tbl_req <= 1'b0;
                        tbl_we  <= 1'b0;
                    end else begin
                        cnt <= cnt + 8'd1;
                    end
                end
                default: begin
                    state   <= IND_IDLE;
                    tbl_req <= 1'b0;
                    tbl_we  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: rtl/cpu_reg_bank.sv
// CPU-visible control/status register bank on the local bus:
// decode, register storage, sticky events, IRQ and read mux.
module cpu_reg_bank
    import cpu_reg_bank_pkg::*;
#(
    parameter int                         CBUS_ADDR_WIDTH = 8,
    parameter int                         CBUS_DATA_WIDTH = 16,
    parameter logic [CBUS_DATA_WIDTH-1:0] VERSION         = 16'h0100,
    parameter int                         TBL_ADDR_WIDTH  = 16,
    parameter int                         TBL_TIMEOUT     = 255
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [CBUS_ADDR_WIDTH-1:0] cpu_lbus_addr,
    input  logic [CBUS_DATA_WIDTH-1:0] cpu_lbus_wdata,
    input  logic                       cpu_lbus_we,
    input  logic                       cpu_lbus_oe,
    output logic [CBUS_DATA_WIDTH-1:0] cpu_lbus_rdata,
    input  logic [7:0]                 evt_in,
    output logic [CBUS_DATA_WIDTH-1:0] ctrl_out,
    output logic                       irq,
    output logic                       tbl_req,
    output logic                       tbl_we,
    output logic [TBL_ADDR_WIDTH-1:0]  tbl_addr,
    output logic [CBUS_DATA_WIDTH-1:0] tbl_wdata,
    input  logic                       tbl_ack,
    input  logic [CBUS_DATA_WIDTH-1:0] tbl_rdata
);

    localparam int AW  = CBUS_ADDR_WIDTH;
    localparam int DW  = CBUS_DATA_WIDTH;
    localparam int TAW = TBL_ADDR_WIDTH;

    logic hit_ver, hit_scr, hit_ctrl, hit_stat, hit_mask;
    logic hit_cnt, hit_iaddr, hit_iwdata, hit_icmd, hit_irdata;

    assign hit_ver    = (cpu_lbus_addr == AW'(OFF_VERSION));
    assign hit_scr    = (cpu_lbus_addr == AW'(OFF_SCRATCH));
    assign hit_ctrl   = (cpu_lbus_addr == AW'(OFF_CTRL));
    assign hit_stat   = (cpu_lbus_addr == AW'(OFF_STATUS));
    assign hit_mask   = (cpu_lbus_addr == AW'(OFF_IRQ_MASK));
    assign hit_cnt    = (cpu_lbus_addr == AW'(OFF_EVT0_CNT));
    assign hit_iaddr  = (cpu_lbus_addr == AW'(OFF_IND_ADDR));
    assign hit_iwdata = (cpu_lbus_addr == AW'(OFF_IND_WDATA));
    assign hit_icmd   = (cpu_lbus_addr == AW'(OFF_IND_CMD));
    assign hit_irdata = (cpu_lbus_addr == AW'(OFF_IND_RDATA));

    logic [DW-1:0]  scratch;
    logic [DW-1:0]  ctrl;
    logic [DW-1:0]  irq_mask;
    logic [7:0]     status;
    logic [DW-1:0]  evt0_cnt;
    logic [TAW-1:0] ind_addr;
    logic [DW-1:0]  ind_wdata;

    logic [7:0]     status_nxt;
    logic [DW-1:0]  cnt_nxt;
    logic [DW-1:0]  rd_mux;
    logic [DW-1:0]  icmd_rd;

    logic           ind_busy;
    logic           ind_done;
    logic           ind_err;
    logic [DW-1:0]  ind_rdata;

    assign ctrl_out = ctrl;

    always_comb begin
        status_nxt = status;
        if (cpu_lbus_we && hit_stat) begin
            status_nxt = status & ~cpu_lbus_wdata[7:0];
        end
        // a new event beats a same-cycle clear
        status_nxt = status_nxt | evt_in;
    end

    always_comb begin
        cnt_nxt = evt0_cnt;
        if (cpu_lbus_oe && hit_cnt) begin
            cnt_nxt = DW'(evt_in[0]);
        end else if (evt_in[0] && (evt0_cnt != {DW{1'b1}})) begin
            cnt_nxt = evt0_cnt + DW'(1);
        end
    end

    always_comb begin
        icmd_rd          = '0;
        icmd_rd[ST_BUSY] = ind_busy;
        icmd_rd[ST_DONE] = ind_done;
        icmd_rd[ST_ERR]  = ind_err;
    end

    always_comb begin
        rd_mux = DW'(RST_DATA);
        unique case (1'b1)
            hit_ver:    rd_mux = VERSION;
            hit_scr:    rd_mux = scratch;
            hit_ctrl:   rd_mux = ctrl;
            hit_stat:   rd_mux = DW'(status);
            hit_mask:   rd_mux = irq_mask;
            hit_cnt:    rd_mux = evt0_cnt;
            hit_iaddr:  rd_mux = DW'(ind_addr);
            hit_iwdata: rd_mux = ind_wdata;
            hit_icmd:   rd_mux = icmd_rd;
            hit_irdata: rd_mux = ind_rdata;
            default:    rd_mux = DW'(RST_DATA);
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            scratch        <= DW'(RST_DATA);
            ctrl           <= DW'(RST_DATA);
            irq_mask       <= DW'(RST_DATA);
            status         <= '0;
            evt0_cnt       <= '0;
            ind_addr       <= '0;
            ind_wdata      <= '0;
            cpu_lbus_rdata <= '0;
            irq            <= 1'b0;
        end else begin
            status         <= status_nxt;
            evt0_cnt       <= cnt_nxt;
            cpu_lbus_rdata <= rd_mux;
            irq            <= |(DW'(status) & irq_mask);
            if (cpu_lbus_we) begin
                if (hit_scr)    scratch   <= cpu_lbus_wdata;
                if (hit_ctrl)   ctrl      <= cpu_lbus_wdata;
                if (hit_mask)   irq_mask  <= cpu_lbus_wdata;
                if (hit_iaddr)  ind_addr  <= TAW'(cpu_lbus_wdata);
                if (hit_iwdata) ind_wdata <= cpu_lbus_wdata;
            end
        end
    end

    cpu_ind_access #(
        .DW          (DW),
        .TAW         (TAW),
        .TBL_TIMEOUT (TBL_TIMEOUT)
    ) u_ind (
        .clk       (clk),
        .rst_n     (rst_n),
        .cmd_wr    (cpu_lbus_we & hit_icmd),
        .cmd_bits  (cpu_lbus_wdata[1:0]),
        .ind_addr  (ind_addr),
        .ind_wdata (ind_wdata),
        .busy      (ind_busy),
        .done      (ind_done),
        .err       (ind_err),
        .ind_rdata (ind_rdata),
        .tbl_req   (tbl_req),
        .tbl_we    (tbl_we),
        .tbl_addr  (tbl_addr),
        .tbl_wdata (tbl_wdata),
        .tbl_ack   (tbl_ack),
        .tbl_rdata (tbl_rdata)
    );

endmodule

// File: tb/tb_cpu_reg_bank.sv
// Directed and randomized checks of cpu_reg_bank against
// a register-level reference model.
module tb_cpu_reg_bank;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [7:0]  addr;
    logic [15:0] wdata;
    logic        we;
    logic        oe;
    logic [15:0] rdata;
    logic [7:0]  evt;
    logic [15:0] ctrl_out;
    logic        irq;
    logic        tbl_req;
    logic        tbl_we;
    logic [15:0] tbl_addr;
    logic [15:0] tbl_wdata;
    logic        tbl_ack;
    logic [15:0] tbl_rdata;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    cpu_reg_bank dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .cpu_lbus_addr  (addr),
        .cpu_lbus_wdata (wdata),
        .cpu_lbus_we    (we),
        .cpu_lbus_oe    (oe),
        .cpu_lbus_rdata (rdata),
        .evt_in         (evt),
        .ctrl_out       (ctrl_out),
        .irq            (irq),
        .tbl_req        (tbl_req),
        .tbl_we         (tbl_we),
        .tbl_addr       (tbl_addr),
        .tbl_wdata      (tbl_wdata),
        .tbl_ack        (tbl_ack),
        .tbl_rdata      (tbl_rdata)
    );

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic bus_wr(input logic [7:0] a, input logic [15:0] d);
        @(negedge clk);
        addr  = a;
        wdata = d;
        we    = 1'b1;
        @(negedge clk);
        we    = 1'b0;
    endtask

    task automatic bus_rd(input logic [7:0] a, output logic [15:0] d);
        @(negedge clk);
        addr = a;
        oe   = 1'b1;
        @(negedge clk);
        oe   = 1'b0;
        d    = rdata;
    endtask

    task automatic pulse_evt(input logic [7:0] e);
        @(negedge clk);
        evt = e;
        @(negedge clk);
        evt = 8'h00;
    endtask

    // reference model state for the randomized phase
    int m_scr, m_ctrl, m_mask, m_stat, m_cnt, m_ia, m_iw;

    function automatic logic [15:0] model_rd(input logic [7:0] a);
        case (a)
            8'h00:   return 16'h0100;
            8'h01:   return 16'(m_scr);
            8'h02:   return 16'(m_ctrl);
            8'h03:   return 16'(m_stat);
            8'h04:   return 16'(m_mask);
            8'h05:   return 16'(m_cnt);
            8'h08:   return 16'(m_ia);
            8'h09:   return 16'(m_iw);
            default: return 16'h0000;
        endcase
    endfunction

    initial begin
        logic [15:0] rd;
        logic [15:0] exp_rd;
        logic        exp_irq;
        logic [7:0]  a;
        logic [7:0]  e;
        logic [15:0] d;
        int          op;
        int          n;

        rst_n     = 1'b0;
        addr      = '0;
        wdata     = '0;
        we        = 1'b0;
        oe        = 1'b0;
        evt       = '0;
        tbl_ack   = 1'b0;
        tbl_rdata = '0;

        repeat (2) @(negedge clk);
        chk("rst_rdata", rdata, 0);
        chk("rst_irq", irq, 0);
        chk("rst_tbl_req", tbl_req, 0);
        chk("rst_tbl_we", tbl_we, 0);
        chk("rst_ctrl", ctrl_out, 0);
        rst_n = 1'b1;

        bus_rd(8'h00, rd);
        chk("version", rd, 16'h0100);
        bus_wr(8'h01, 16'hA5A5);
        bus_rd(8'h01, rd);
        chk("scratch", rd, 16'hA5A5);
        bus_rd(8'h3F, rd);
        chk("unmapped", rd, 16'h0000);
        bus_wr(8'h00, 16'hFFFF);
        bus_rd(8'h00, rd);
        chk("version_ro", rd, 16'h0100);
        bus_wr(8'h02, 16'h1234);
        chk("ctrl_out", ctrl_out, 16'h1234);

        bus_wr(8'h04, 16'h0004);
        chk("irq_masked_idle", irq, 0);
        pulse_evt(8'h04);
        bus_rd(8'h03, rd);
        chk("status_set", rd, 16'h0004);
        chk("irq_set", irq, 1);
        bus_wr(8'h03, 16'h0004);
        chk("irq_lag", irq, 1);
        @(negedge clk);
        chk("irq_clr", irq, 0);
        bus_rd(8'h03, rd);
        chk("status_clr", rd, 16'h0000);

        repeat (3) pulse_evt(8'h01);
        bus_rd(8'h05, rd);
        chk("evt0_cnt3", rd, 3);
        bus_rd(8'h05, rd);
        chk("evt0_cor", rd, 0);

        @(negedge clk);
        evt = 8'h01;
        repeat (65536) @(negedge clk);
        bus_rd(8'h05, rd);
        evt = 8'h00;
        chk("evt0_sat", rd, 16'hFFFF);
        bus_rd(8'h05, rd);
        chk("evt0_clr_evt", rd, 1);

        bus_wr(8'h08, 16'h1234);
        bus_wr(8'h09, 16'hBEEF);
        bus_wr(8'h0A, 16'h0001);
        chk("iw_req", tbl_req, 1);
        chk("iw_we", tbl_we, 1);
        chk("iw_addr", tbl_addr, 16'h1234);
        chk("iw_wdata", tbl_wdata, 16'hBEEF);
        bus_wr(8'h08, 16'h9999);
        bus_wr(8'h0A, 16'h0002);
        chk("iw_addr_hold", tbl_addr, 16'h1234);
        chk("iw_cmd_ignored", tbl_we, 1);
        bus_rd(8'h0A, rd);
        chk("iw_busy", rd, 16'h0001);
        @(negedge clk);
        tbl_ack = 1'b1;
        @(negedge clk);
        tbl_ack = 1'b0;
        chk("iw_req_drop", tbl_req, 0);
        bus_rd(8'h0A, rd);
        chk("iw_done", rd, 16'h0002);

        bus_wr(8'h0A, 16'h0002);
        chk("ir_req", tbl_req, 1);
        chk("ir_we", tbl_we, 0);
        chk("ir_addr", tbl_addr, 16'h9999);
        repeat (3) @(negedge clk);
        tbl_ack   = 1'b1;
        tbl_rdata = 16'h5A5A;
        @(negedge clk);
        tbl_ack   = 1'b0;
        tbl_rdata = 16'h0000;
        bus_rd(8'h0B, rd);
        chk("ir_rdata", rd, 16'h5A5A);
        bus_rd(8'h0A, rd);
        chk("ir_done", rd, 16'h0002);

        @(negedge clk);
        tbl_ack   = 1'b1;
        tbl_rdata = 16'h1111;
        @(negedge clk);
        tbl_ack   = 1'b0;
        chk("idle_ack_req", tbl_req, 0);
        bus_rd(8'h0B, rd);
        chk("idle_ack_rdata", rd, 16'h5A5A);

        bus_wr(8'h0A, 16'h0003);
        chk("both_bits_we", tbl_we, 1);
        n = 0;
        while (tbl_req === 1'b1 && n < 400) begin
            n++;
            @(negedge clk);
        end
        chk("timeout_cycles", n, 255);
        bus_rd(8'h0A, rd);
        chk("timeout_err", rd, 16'h0004);
        bus_rd(8'h0B, rd);
        chk("timeout_rdata", rd, 16'h5A5A);

        bus_wr(8'h0A, 16'h0001);
        chk("mid_req", tbl_req, 1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_req", tbl_req, 0);
        chk("mid_rst_we", tbl_we, 0);
        @(negedge clk);
        rst_n = 1'b1;
        bus_rd(8'h0A, rd);
        chk("mid_rst_cmd", rd, 16'h0000);

        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n  = 1'b1;
        m_scr  = 0;
        m_ctrl = 0;
        m_mask = 0;
        m_stat = 0;
        m_cnt  = 0;
        m_ia   = 0;
        m_iw   = 0;
        exp_rd  = '0;
        exp_irq = 1'b0;
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            if (i > 0) begin
                chk("rnd_rdata", rdata, exp_rd);
                chk("rnd_irq", irq, exp_irq);
                chk("rnd_ctrl", ctrl_out, m_ctrl);
            end
            op = int'($urandom_range(0, 2));
            if ($urandom_range(0, 7) == 0) a = 8'($urandom);
            else a = 8'($urandom_range(0, 11));
            d = 16'($urandom);
            e = 8'($urandom & $urandom & $urandom);
            if (op == 1 && a == 8'h0A) op = 0;
            addr  = a;
            wdata = d;
            we    = (op == 1);
            oe    = (op == 2);
            evt   = e;
            exp_rd  = model_rd(a);
            exp_irq = ((m_stat & m_mask) != 0);
            if (op == 1) begin
                case (a)
                    8'h01: m_scr  = int'(d);
                    8'h02: m_ctrl = int'(d);
                    8'h03: m_stat = m_stat & ~int'(d[7:0]);
                    8'h04: m_mask = int'(d);
                    8'h08: m_ia   = int'(d);
                    8'h09: m_iw   = int'(d);
                    default: ;
                endcase
            end
            m_stat = m_stat | int'(e);
            if (op == 2 && a == 8'h05) m_cnt = int'(e[0]);
            else if (e[0] && m_cnt < 65535) m_cnt = m_cnt + 1;
        end
        @(negedge clk);
        chk("rnd_rdata", rdata, exp_rd);
        chk("rnd_irq", irq, exp_irq);
        chk("rnd_ctrl", ctrl_out, m_ctrl);
        we  = 1'b0;
        oe  = 1'b0;
        evt = 8'h00;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
